sr_latch_driver: RTL and testbench

//  Clocked initiator for the gated NAND SR latch (ports En/S/R in, Q/notQ out).
//  - Turns a one-bit write request into a timed S/R/En sequence, then reads Q/notQ back.
//  - Verifies the stored value, retries on mismatch, and reports done or error to the requester.
//  - Lets lab designs drive the latch from synchronous logic without violating its setup or hold windows.

---
 rtl/sr_drv_pkg.sv | 24 ++
 rtl/sync2.sv | 23 ++
 rtl/sr_latch_driver.sv | 167 ++++++++++++++++
 tb/tb_sr_latch_driver.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sr_drv_pkg.sv
// Shared types and default timing for the gated SR latch driver.
package sr_drv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        SETTLE,
        CHECK
    } drvState_t;

    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_PULSE_CYC  = 2;
    localparam int DEF_SETTLE_CYC = 3;
    localparam int DEF_MAX_RETRY  = 1;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs; both stages clear on reset.
module sync2 #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/sr_latch_driver.sv
// Sequences S/R/En into a gated NAND SR latch, reads it back through a
// synchroniser, retries on mismatch and reports done/error to the requester.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int PULSE_CYC  = DEF_PULSE_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int MAX_RETRY  = DEF_MAX_RETRY
) (
    input  logic Clk,
    input  logic Rst,
    input  logic WrReq,
    input  logic WrData,
    output logic WrAck,
    output logic Busy,
    output logic Err,
    output logic RdQ,
    output logic S,
    output logic R,
    output logic En,
    input  logic Q,
    input  logic notQ
);

    localparam int CW = $clog2(maxOf3(SETUP_CYC, PULSE_CYC, SETTLE_CYC)) + 1;
    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [2:0]    RETRY_LIM = 3'(MAX_RETRY);

    drvState_t     state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [2:0]    retryCnt, retryNext;
    logic          d, dNext;
    logic          sNext, rNext, enNext, ackNext, busyNext, errNext, rdqNext;
    logic [1:0]    qPair;
    logic          qs, nqs, pass;

    sync2 #(.W(2)) uSync (
        .clk (Clk),
        .rst (Rst),
        .din ({Q, notQ}),
        .dout(qPair)
    );

    assign qs   = qPair[1];
    assign nqs  = qPair[0];
    // An equal pair (invalid or metastable) can never satisfy both terms.
    assign pass = (qs == d) && (nqs == ~d);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            retryCnt <= '0;
            d        <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            En       <= 1'b0;
            WrAck    <= 1'b0;
            Busy     <= 1'b0;
            Err      <= 1'b0;
            RdQ      <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            retryCnt <= retryNext;
            d        <= dNext;
            S        <= sNext;
            R        <= rNext;
            En       <= enNext;
            WrAck    <= ackNext;
            Busy     <= busyNext;
            Err      <= errNext;
            RdQ      <= rdqNext;
        end
    end

    // Outputs are registered, so each branch drives the values for the
    // state being entered, not the one being left.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        retryNext = retryCnt;
        dNext     = d;
        sNext     = 1'b0;
        rNext     = 1'b0;
        enNext    = 1'b0;
        ackNext   = 1'b0;
        busyNext  = Busy;
        errNext   = Err;
        rdqNext   = RdQ;
        case (state)
            IDLE: begin
                if (WrReq) begin
                    dNext     = WrData;
                    errNext   = 1'b0;
                    busyNext  = 1'b1;
                    retryNext = '0;
                    cntNext   = SETUP_LD;
                    stateNext = SETUP;
                    sNext     = WrData;
                    rNext     = ~WrData;
                end
            end
            SETUP: begin
                sNext = d;
                rNext = ~d;
                if (cnt == '0) begin
                    cntNext   = PULSE_LD;
                    stateNext = PULSE;
                    enNext    = 1'b1;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            PULSE: begin
                sNext = d;
                rNext = ~d;
                if (cnt == '0) begin
                    stateNext = HOLD;
                end else begin
                    cntNext = cnt - 1'b1;
                    enNext  = 1'b1;
                end
            end
            HOLD: begin
                cntNext   = SETTLE_LD;
                stateNext = SETTLE;
            end
            SETTLE: begin
                if (cnt == '0) begin
                    // Verdict is taken here so WrAck/RdQ/Err are visible in CHECK.
                    stateNext = CHECK;
                    if (pass) begin
                        rdqNext = d;
                        ackNext = 1'b1;
                    end else if (retryCnt < RETRY_LIM) begin
                        retryNext = retryCnt + 3'd1;
                    end else begin
                        errNext = 1'b1;
                        ackNext = 1'b1;
                    end
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            CHECK: begin
                if (WrAck) begin
                    busyNext  = 1'b0;
                    stateNext = IDLE;
                end else begin
                    cntNext   = SETUP_LD;
                    stateNext = SETUP;
                    sNext     = d;
                    rNext     = ~d;
                end
            end
            default: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver against a behavioural NAND SR latch.
module tb_sr_latch_driver;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic WrReq = 1'b0;
    logic WrData = 1'b0;
    logic WrAck, Busy, Err, RdQ, S, R, En, Q, notQ;
    logic sn, rn;
    logic stuck0 = 1'b1;
    logic monOn = 1'b0;
    logic pS, pR, pEn;
    int   total = 0;
    int   bad = 0;

    sr_latch_driver dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .WrReq (WrReq),
        .WrData(WrData),
        .WrAck (WrAck),
        .Busy  (Busy),
        .Err   (Err),
        .RdQ   (RdQ),
        .S     (S),
        .R     (R),
        .En    (En),
        .Q     (Q),
        .notQ  (notQ)
    );

    always #5 Clk = ~Clk;

    // Gated NAND SR latch; stuck0 pins Q low (power-up init and fault injection).
    assign #2 sn   = ~(S & En);
    assign #2 rn   = ~(R & En);
    assign #2 Q    = stuck0 ? 1'b0 : ~(sn & notQ);
    assign #2 notQ = ~(rn & Q);

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (monOn) begin
            chk("inv_s_and_r", S & R, 1'b0);
            if (En && pEn) chk("inv_sr_stable", {S, R}, {pS, pR});
        end
        pS  <= S;
        pR  <= R;
        pEn <= En;
    end

    // One write of `attempts` full attempts; checks the phase-by-phase drive pattern.
    task automatic doWrite(input logic data, input int attempts, input logic expErr,
                           input logic expRdQ);
        int last;
        int p;
        last = 8 * attempts;
        @(negedge Clk);
        WrReq  = 1'b1;
        WrData = data;
        for (int c = 1; c <= last; c++) begin
            @(negedge Clk);
            WrReq  = 1'b0;
            WrData = ~data;
            p = (c - 1) % 8;
            chk("en",   En,    (p == 1 || p == 2));
            chk("s",    S,     data && p <= 3);
            chk("r",    R,     !data && p <= 3);
            chk("ack",  WrAck, c == last);
            chk("busy", Busy,  1'b1);
            if (c == 1) chk("err_clr", Err, 1'b0);
        end
        chk("err", Err, expErr);
        chk("rdq", RdQ, expRdQ);
        @(negedge Clk);
        chk("busy_drop", Busy, 1'b0);
        chk("ack_drop",  WrAck, 1'b0);
    endtask

    initial begin
        // 1: reset
        repeat (2) @(negedge Clk);
        chk("rst_s", S, 1'b0);
        chk("rst_r", R, 1'b0);
        chk("rst_en", En, 1'b0);
        chk("rst_ack", WrAck, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_err", Err, 1'b0);
        chk("rst_rdq", RdQ, 1'b0);
        Rst    = 1'b0;
        stuck0 = 1'b0;
        monOn  = 1'b1;

        // 2, 3: plain writes of 1 then 0
        doWrite(1'b1, 1, 1'b0, 1'b1);
        chk("latch_q1", Q, 1'b1);
        doWrite(1'b0, 1, 1'b0, 1'b0);
        chk("latch_q0", Q, 1'b0);

        // 4: latch stuck low -> one retry, then error; next write clears Err
        stuck0 = 1'b1;
        doWrite(1'b1, 2, 1'b1, 1'b0);
        stuck0 = 1'b0;
        doWrite(1'b1, 1, 1'b0, 1'b1);

        // 5: reset during PULSE
        @(negedge Clk);
        WrReq  = 1'b1;
        WrData = 1'b0;
        @(negedge Clk);
        WrReq = 1'b0;
        chk("r5_s", S, 1'b0);
        chk("r5_r", R, 1'b1);
        @(negedge Clk);
        chk("r5_en", En, 1'b1);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("r5_en_drop", En, 1'b0);
        chk("r5_s_drop", S, 1'b0);
        chk("r5_r_drop", R, 1'b0);
        chk("r5_busy", Busy, 1'b0);
        chk("r5_rdq", RdQ, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("r5_no_ack", WrAck, 1'b0);
        end
        doWrite(1'b1, 1, 1'b0, 1'b1);

        // 6: WrReq held high with WrData toggling every cycle
        for (int c = 0; c <= 26; c++) begin
            if (c > 0) @(negedge Clk);
            if (c > 0) begin
                chk("b2b_ack", WrAck, (c % 9) == 8);
                chk("b2b_busy", Busy, (c % 9) != 0);
                if ((c % 9) == 8) chk("b2b_rdq", RdQ, ((c - 8) % 2) == 0);
            end
            WrReq  = (c < 26);
            WrData = (c % 2) == 0;
        end
        @(negedge Clk);
        chk("b2b_idle", Busy, 1'b0);
        chk("b2b_latch", Q, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
